// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - pipelined barrel shifter (LSL/ROL/LSR/ASR/ROR), one register per binary stage.
// Optional out_carry and operand copy registers are enabled by defining SHIFTER_CARRY_EN.
module pipelined_shifter #(
  parameter int WIDTH = 32,
  parameter int SA_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SA_W-1:0]  in_amount,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_err
`ifdef SHIFTER_CARRY_EN
  , output logic           out_carry
`endif
);

  localparam logic [2:0] MODE_LSL = 3'd0;
  localparam logic [2:0] MODE_ROL = 3'd1;
  localparam logic [2:0] MODE_LSR = 3'd2;
  localparam logic [2:0] MODE_ASR = 3'd3;
  localparam logic [2:0] MODE_ROR = 3'd4;

  logic             valid_q [SA_W];
  logic             valid_d [SA_W];
  logic [WIDTH-1:0] data_q  [SA_W];
  logic [WIDTH-1:0] data_d  [SA_W];
  logic [SA_W-1:0]  amt_q   [SA_W];
  logic [SA_W-1:0]  amt_d   [SA_W];
  logic [2:0]       mode_q  [SA_W];
  logic [2:0]       mode_d  [SA_W];
  logic             err_q   [SA_W];
  logic             err_d   [SA_W];
`ifdef SHIFTER_CARRY_EN
  logic [WIDTH-1:0] opnd_q  [SA_W];
  logic [WIDTH-1:0] opnd_d  [SA_W];
`endif

  logic            advance;
  logic [SA_W-1:0] sel;

  // Illegal modes fall through to the default arm and pass data unchanged.
  function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] d,
                                                   input logic [2:0] mode,
                                                   input int s);
    logic signed [WIDTH-1:0] sd;
    logic [WIDTH-1:0]        r;
    sd = d;
    case (mode)
      MODE_LSL: r = d << s;
      MODE_ROL: r = (d << s) | (d >> (WIDTH - s));
      MODE_LSR: r = d >> s;
      MODE_ASR: r = sd >>> s;
      MODE_ROR: r = (d >> s) | (d << (WIDTH - s));
      default:  r = d;
    endcase
    return r;
  endfunction

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;

  always_comb begin
    sel       = '0;
    valid_d[0] = in_valid && in_ready;
    data_d[0]  = in_amount[0] ? shift_stage(in_data, in_mode, 1) : in_data;
    amt_d[0]   = in_amount;
    mode_d[0]  = in_mode;
    err_d[0]   = (in_mode > MODE_ROR);
`ifdef SHIFTER_CARRY_EN
    opnd_d[0]  = in_data;
`endif
    for (int k = 1; k < SA_W; k++) begin
      sel        = amt_q[k-1] >> k;
      valid_d[k] = valid_q[k-1];
      data_d[k]  = sel[0] ? shift_stage(data_q[k-1], mode_q[k-1], 1 << k) : data_q[k-1];
      amt_d[k]   = amt_q[k-1];
      mode_d[k]  = mode_q[k-1];
      err_d[k]   = err_q[k-1];
`ifdef SHIFTER_CARRY_EN
      opnd_d[k]  = opnd_q[k-1];
`endif
    end
  end

  // The whole pipe freezes on a stall; flush only clears the valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SA_W; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
        amt_q[k]   <= '0;
        mode_q[k]  <= '0;
        err_q[k]   <= 1'b0;
`ifdef SHIFTER_CARRY_EN
        opnd_q[k]  <= '0;
`endif
      end
    end else begin
      for (int k = 0; k < SA_W; k++) begin
        if (flush) begin
          valid_q[k] <= 1'b0;
        end else if (advance) begin
          valid_q[k] <= valid_d[k];
        end
        if (advance) begin
          data_q[k] <= data_d[k];
          amt_q[k]  <= amt_d[k];
          mode_q[k] <= mode_d[k];
          err_q[k]  <= err_d[k];
`ifdef SHIFTER_CARRY_EN
          opnd_q[k] <= opnd_d[k];
`endif
        end
      end
    end
  end

  assign out_valid = valid_q[SA_W-1];
  assign out_data  = data_q[SA_W-1];
  assign out_zero  = (data_q[SA_W-1] == '0);
  assign out_err   = err_q[SA_W-1];

`ifdef SHIFTER_CARRY_EN
  logic [SA_W-1:0] carry_amt;
  logic [SA_W-1:0] carry_idx;

  // Left shifts lose operand[WIDTH-amt] last; right shifts lose operand[amt-1].
  always_comb begin
    carry_amt = amt_q[SA_W-1];
    carry_idx = '0;
    out_carry = 1'b0;
    if (!err_q[SA_W-1] && (carry_amt != '0)) begin
      if ((mode_q[SA_W-1] == MODE_LSL) || (mode_q[SA_W-1] == MODE_ROL)) begin
        carry_idx = '0 - carry_amt;
      end else begin
        carry_idx = carry_amt - SA_W'(1);
      end
      out_carry = opnd_q[SA_W-1][carry_idx];
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb/tb_pipelined_shifter.sv - directed self-checking bench for pipelined_shifter at WIDTH=32.
module tb_pipelined_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_amount = '0;
  logic [2:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_zero;
  logic        out_err;
`ifdef SHIFTER_CARRY_EN
  logic        out_carry;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_shifter #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_amount(in_amount),
    .in_mode(in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_zero(out_zero),
    .out_err(out_err)
`ifdef SHIFTER_CARRY_EN
    , .out_carry(out_carry)
`endif
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] d, input logic [4:0] a, input logic [2:0] m,
                        output logic [31:0] res, output logic z, output logic e,
                        output logic c, output int lat);
    in_data = d; in_amount = a; in_mode = m; in_valid = 1'b1; out_ready = 1'b1;
    step;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step;
      lat++;
    end
    res = out_data; z = out_zero; e = out_err;
`ifdef SHIFTER_CARRY_EN
    c = out_carry;
`else
    c = 1'b0;
`endif
    step;
  endtask

  task automatic test_reset;
    step; step;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (out_zero !== 1'b1) begin errors++; $display("FAIL reset_out_zero got %b want 1", out_zero); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b want 0", out_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
`ifdef SHIFTER_CARRY_EN
    checks++; if (out_carry !== 1'b0) begin errors++; $display("FAIL reset_out_carry got %b want 0", out_carry); end
`endif
    rst = 1'b0;
    step;
  endtask

  task automatic test_shifts;
    logic [31:0] vd [11] = '{32'h00000001, 32'h80000000, 32'h80000000, 32'h80000000, 32'h00000001,
                             32'h12345678, 32'h12345678, 32'h80000001, 32'hDEADBEEF, 32'h7FFFFFFF,
                             32'hFFFFFFFF};
    logic [4:0]  va [11] = '{5'd31, 5'd4, 5'd4, 5'd1, 5'd1, 5'd8, 5'd4, 5'd0, 5'd5, 5'd31, 5'd31};
    logic [2:0]  vm [11] = '{3'd0, 3'd3, 3'd2, 3'd0, 3'd4, 3'd1, 3'd4, 3'd3, 3'd6, 3'd3, 3'd2};
    logic [31:0] ve [11] = '{32'h80000000, 32'hF8000000, 32'h08000000, 32'h00000000, 32'h80000000,
                             32'h34567812, 32'h81234567, 32'h80000001, 32'hDEADBEEF, 32'h00000000,
                             32'h00000001};
    logic        vz [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        ve_err [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        vc [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] res;
    logic        z, e, c;
    int          lat;
    for (int i = 0; i < 11; i++) begin
      run_op(vd[i], va[i], vm[i], res, z, e, c, lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL shift%0d_latency got %0d want 5", i, lat); end
      checks++; if (res !== ve[i]) begin errors++; $display("FAIL shift%0d_data got %h want %h", i, res, ve[i]); end
      checks++; if (z !== vz[i]) begin errors++; $display("FAIL shift%0d_zero got %b want %b", i, z, vz[i]); end
      checks++; if (e !== ve_err[i]) begin errors++; $display("FAIL shift%0d_err got %b want %b", i, e, ve_err[i]); end
`ifdef SHIFTER_CARRY_EN
      checks++; if (c !== vc[i]) begin errors++; $display("FAIL shift%0d_carry got %b want %b", i, c, vc[i]); end
`endif
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] od [8] = '{32'h00000003, 32'hF0000000, 32'hF0000000, 32'h80000001,
                            32'h80000001, 32'h0000FFFF, 32'h000000FF, 32'h00000100};
    logic [4:0]  oa [8] = '{5'd2, 5'd8, 5'd8, 5'd1, 5'd1, 5'd16, 5'd4, 5'd9};
    logic [2:0]  om [8] = '{3'd0, 3'd2, 3'd3, 3'd1, 3'd4, 3'd0, 3'd4, 3'd2};
    logic [31:0] ex [8] = '{32'h0000000C, 32'h00F00000, 32'hFFF00000, 32'h00000003,
                            32'hC0000000, 32'hFFFF0000, 32'hF000000F, 32'h00000000};
    int          issued = 0;
    int          recv = 0;
    int          stall_lo = 0;
    int          extra = 0;
    logic [31:0] held = '0;
    logic        held_v = 1'b0;
    for (int c = 0; c < 60 && recv < 8; c++) begin
      out_ready = !(c >= 6 && c < 10);
      in_valid  = (issued < 8);
      if (issued < 8) begin
        in_data = od[issued]; in_amount = oa[issued]; in_mode = om[issued];
      end
      #1;
      if (!out_ready && in_ready === 1'b0) stall_lo++;
      if (out_valid && !out_ready) begin
        if (held_v) begin
          checks++; if (out_data !== held) begin errors++; $display("FAIL b2b_hold got %h want %h", out_data, held); end
        end
        held = out_data; held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++; if (out_data !== ex[recv]) begin errors++; $display("FAIL b2b_result%0d got %h want %h", recv, out_data, ex[recv]); end
        recv++;
      end
      if (in_valid && in_ready) issued++;
      step;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) extra++;
      step;
    end
    checks++; if (recv !== 8) begin errors++; $display("FAIL b2b_count got %0d want 8", recv); end
    checks++; if (stall_lo !== 4) begin errors++; $display("FAIL b2b_in_ready_stall got %0d low cycles want 4", stall_lo); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_duplicates got %0d want 0", extra); end
  endtask

  task automatic test_flush;
    int          cnt = 0;
    int          lat_at = 0;
    logic [31:0] got = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h00000011 << i; in_amount = 5'(i + 1); in_mode = 3'd0;
      step;
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h00000055; in_amount = 5'd0; in_mode = 3'd0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
    step;
    flush = 1'b0;
    in_valid = 1'b1; in_data = 32'h80000000; in_amount = 5'd31; in_mode = 3'd2;
    step;
    in_valid = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      if (out_valid) begin
        cnt++; got = out_data; lat_at = c;
      end
      step;
    end
    checks++; if (cnt !== 1) begin errors++; $display("FAIL flush_result_count got %0d want 1", cnt); end
    checks++; if (got !== 32'h00000001) begin errors++; $display("FAIL flush_post_data got %h want 00000001", got); end
    checks++; if (lat_at !== 5) begin errors++; $display("FAIL flush_post_latency got %0d want 5", lat_at); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] res;
    logic        z, e, c;
    int          lat;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'hA5A5A5A5; in_amount = 5'd3; in_mode = 3'd6;
    for (int i = 0; i < 7; i++) step;
    checks++; if (out_valid !== 1'b1 || out_err !== 1'b1) begin errors++; $display("FAIL rstmid_pre got valid=%b err=%b want 1 1", out_valid, out_err); end
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rstmid_out_data got %h want 0", out_data); end
    checks++; if (out_zero !== 1'b1) begin errors++; $display("FAIL rstmid_out_zero got %b want 1", out_zero); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL rstmid_out_err got %b want 0", out_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
`ifdef SHIFTER_CARRY_EN
    checks++; if (out_carry !== 1'b0) begin errors++; $display("FAIL rstmid_out_carry got %b want 0", out_carry); end
`endif
    step; step;
    rst = 1'b0;
    run_op(32'h12345678, 5'd4, 3'd4, res, z, e, c, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL rstmid_post_latency got %0d want 5", lat); end
    checks++; if (res !== 32'h81234567) begin errors++; $display("FAIL rstmid_post_data got %h want 81234567", res); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL rstmid_post_err got %b want 0", e); end
`ifdef SHIFTER_CARRY_EN
    checks++; if (c !== 1'b1) begin errors++; $display("FAIL rstmid_post_carry got %b want 1", c); end
`endif
  endtask

  initial begin
    test_reset;
    test_shifts;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
